// File: rtl/tdm_bram_if.sv
// Bus bundle for tdm_bram: per-port instruction read channels plus one data port.
interface tdm_bram_if #(
    parameter int NUM_IPORTS = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_SIZE  = 16
) ();
    logic [NUM_IPORTS-1:0]            ireq;
    logic [NUM_IPORTS*ADDR_WIDTH-1:0] iaddr;
    logic [NUM_IPORTS*16-1:0]         iout;
    logic [NUM_IPORTS-1:0]            ivalid;
    logic                             dre;
    logic                             dwe;
    logic [ADDR_WIDTH-1:0]            daddr;
    logic [WORD_SIZE-1:0]             din;
    logic [WORD_SIZE-1:0]             dout;
    logic                             dvalid;

    modport master (
        output ireq, iaddr, dre, dwe, daddr, din,
        input  iout, ivalid, dout, dvalid
    );

    modport slave (
        input  ireq, iaddr, dre, dwe, daddr, din,
        output iout, ivalid, dout, dvalid
    );
endinterface

// File: rtl/tdm_bram.sv
// Time-multiplexed instruction ROM shared by NUM_IPORTS requesters through a
// round-robin arbiter, alongside an independent single-port data RAM.
module tdm_bram #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_IPORTS = 2,
    parameter int RDW_MODE   = 0
) (
    input  logic      clk,
    input  logic      rst,
    tdm_bram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = (NUM_IPORTS > 1) ? $clog2(NUM_IPORTS) : 1;

    // Instruction memory image: fixed contents, read-only at runtime, so it
    // is expressed as a ROM function of the address.
    function automatic logic [15:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'd40503;
        return p[15:0] ^ 16'hA5C3;
    endfunction

    logic [NUM_IPORTS-1:0][ADDR_WIDTH-1:0] iaddr_v;
    logic [NUM_IPORTS-1:0][15:0]           iout_q;
    logic [NUM_IPORTS-1:0]                 ivalid_q;
    logic [NUM_IPORTS-1:0]                 elig;
    logic [PW-1:0]                         ptr;
    logic [PW-1:0]                         gnt_idx;
    logic                                  gnt_vld;

    logic [WORD_SIZE-1:0] dmem [DEPTH];
    logic [WORD_SIZE-1:0] dout_q;
    logic                 dvalid_q;

    assign iaddr_v    = bus.iaddr;
    assign bus.iout   = iout_q;
    assign bus.ivalid = ivalid_q;
    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;

    // A port being answered this cycle sits out, so it never has two reads in flight.
    assign elig = bus.ireq & ~ivalid_q;

    // Round-robin pick: first eligible port at or after the priority pointer.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_IPORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_IPORTS;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    // Registered ROM read for the granted port; pointer advances past the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            ivalid_q <= '0;
            iout_q   <= '0;
        end else begin
            ivalid_q <= '0;
            if (gnt_vld) begin
                ivalid_q[gnt_idx] <= 1'b1;
                iout_q[gnt_idx]   <= rom_word(iaddr_v[gnt_idx]);
                ptr <= (gnt_idx == PW'(NUM_IPORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Data port: writes are blocked while rst is high (memory itself is never cleared);
    // a read colliding with a write returns old or new data depending on RDW_MODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= bus.dre;
            if (bus.dre)
                dout_q <= (RDW_MODE != 0 && bus.dwe) ? bus.din : dmem[bus.daddr];
            if (bus.dwe)
                dmem[bus.daddr] <= bus.din;
        end
    end
endmodule

// File: tb/tb_tdm_bram.sv
// Directed and model-checked bench for tdm_bram (2-port old-data and 4-port write-through builds).
module tb_tdm_bram;
    localparam int AW = 10;
    localparam int WS = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tdm_bram_if #(.NUM_IPORTS(2), .ADDR_WIDTH(AW), .WORD_SIZE(WS)) b2 ();
    tdm_bram_if #(.NUM_IPORTS(4), .ADDR_WIDTH(AW), .WORD_SIZE(WS)) b4 ();

    tdm_bram #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_IPORTS(2), .RDW_MODE(0))
        dut2 (.clk(clk), .rst(rst), .bus(b2));
    tdm_bram #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_IPORTS(4), .RDW_MODE(1))
        dut4 (.clk(clk), .rst(rst), .bus(b4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Instruction memory image as loaded in the device.
    function automatic logic [15:0] imem_ref(input logic [AW-1:0] a);
        int v;
        v = (int'(a) * 40503) & 16'hFFFF;
        return 16'(v) ^ 16'hA5C3;
    endfunction

    // Reference model state for the random phase
    logic [1:0]         m_iv, rq, el;
    logic [1:0][15:0]   m_io;
    logic [1:0][AW-1:0] ad;
    logic [15:0]        m_dm [16];
    logic [15:0]        m_do, rdin;
    logic               m_dv, rdwe, rdre;
    int                 m_ptr, g, rda;

    initial begin
        b2.ireq = '0; b2.iaddr = '0; b2.dre = 0; b2.dwe = 0; b2.daddr = '0; b2.din = '0;
        b4.ireq = '0; b4.iaddr = '0; b4.dre = 0; b4.dwe = 0; b4.daddr = '0; b4.din = '0;

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_iout2", b2.iout, 0);
        chk("rst_ivalid2", b2.ivalid, 0);
        chk("rst_dout2", b2.dout, 0);
        chk("rst_dvalid2", b2.dvalid, 0);
        chk("rst_iout4", b4.iout, 0);
        tick(); tick();
        rst = 1'b0;

        // two ports requesting continuously: alternate starting at port 0
        b2.ireq = 2'b11; b2.iaddr = {10'd9, 10'd5};
        tick();
        chk("alt_c1_ivalid", b2.ivalid, 2'b01);
        chk("alt_c1_iout0", b2.iout[15:0], 16'hB2D0);
        tick();
        chk("alt_c2_ivalid", b2.ivalid, 2'b10);
        chk("alt_c2_iout", b2.iout, {16'h2A2C, 16'hB2D0});
        tick();
        chk("alt_c3_ivalid", b2.ivalid, 2'b01);
        tick();
        chk("alt_c4_ivalid", b2.ivalid, 2'b10);
        b2.ireq = 2'b00;
        tick();
        chk("alt_idle_ivalid", b2.ivalid, 2'b00);
        chk("alt_idle_hold", b2.iout, {16'h2A2C, 16'hB2D0});

        // 4 ports: port 2 alone, then 0 and 3 together -> order 2,3,0
        b4.iaddr = {10'd7, 10'd3, 10'd0, 10'd0};
        b4.ireq = 4'b0100;
        tick();
        chk("rr4_g2", b4.ivalid, 4'b0100);
        chk("rr4_iout2", b4.iout[47:32], 16'h7F66);
        b4.ireq = 4'b1001;
        tick();
        chk("rr4_g3", b4.ivalid, 4'b1000);
        chk("rr4_iout3", b4.iout[63:48], 16'hF642);
        b4.ireq = 4'b0001;
        tick();
        chk("rr4_g0", b4.ivalid, 4'b0001);
        chk("rr4_iout0", b4.iout[15:0], 16'hA5C3);
        b4.ireq = 4'b0000;

        // read-during-write, both modes
        b2.dwe = 1; b2.daddr = 10'h10; b2.din = 16'h1234;
        b4.dwe = 1; b4.daddr = 10'h10; b4.din = 16'h1234;
        tick();
        chk("d_wr_nodvalid", b2.dvalid, 0);
        b2.din = 16'hBEEF; b2.dre = 1;
        b4.din = 16'hBEEF; b4.dre = 1;
        tick();
        chk("rdw0_dvalid", b2.dvalid, 1);
        chk("rdw0_dout", b2.dout, 16'h1234);
        chk("rdw1_dout", b4.dout, 16'hBEEF);
        b2.dwe = 0; b4.dwe = 0;
        tick();
        chk("rdw0_next", b2.dout, 16'hBEEF);
        chk("rdw1_next", b4.dout, 16'hBEEF);
        b2.dre = 0; b4.dre = 0;
        tick();
        chk("d_dvalid_drop", b2.dvalid, 0);
        chk("d_dout_hold", b2.dout, 16'hBEEF);

        // asynchronous reset with a grant pending
        b2.ireq = 2'b01; b2.iaddr = {10'd9, 10'd5};
        tick();
        chk("ar_pre_g0", b2.ivalid, 2'b01);
        b2.ireq = 2'b10;
        #2 rst = 1'b1;
        b2.dwe = 1; b2.daddr = 10'h10; b2.din = 16'hDEAD;
        #1;
        chk("ar_iout0", b2.iout, 0);
        chk("ar_ivalid0", b2.ivalid, 0);
        chk("ar_dout0", b2.dout, 0);
        chk("ar_dvalid0", b2.dvalid, 0);
        tick();
        chk("ar_noivalid", b2.ivalid, 0);
        tick();
        rst = 1'b0; b2.dwe = 0; b2.ireq = 2'b11;
        tick();
        chk("ar_port0_first", b2.ivalid, 2'b01);
        chk("ar_rom_same", b2.iout[15:0], 16'hB2D0);
        b2.ireq = 2'b00; b2.dre = 1; b2.daddr = 10'h10;
        tick();
        chk("ar_nowrite", b2.dout, 16'hBEEF);
        b2.dre = 0;

        // random concurrent traffic against a reference model
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        m_iv = '0; m_io = '0; m_ptr = 0; m_do = '0; m_dv = 0; rq = '0; ad = '0;
        for (int c = 0; c < 1016; c++) begin
            if (c > 0) tick();
            chk("rnd_ivalid", b2.ivalid, m_iv);
            chk("rnd_iout", b2.iout, m_io);
            chk("rnd_dvalid", b2.dvalid, m_dv);
            chk("rnd_dout", b2.dout, m_do);
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || m_iv[p]) begin
                    rq[p] = ($urandom_range(0, 3) != 0);
                    ad[p] = AW'($urandom_range(0, 1023));
                end
            end
            if (c < 16) begin
                rdwe = 1; rdre = 0; rda = c;
            end else begin
                rdwe = 1'($urandom_range(0, 1));
                rdre = 1'($urandom_range(0, 1));
                rda  = $urandom_range(0, 15);
            end
            rdin = 16'($urandom);
            b2.ireq = rq; b2.iaddr = ad;
            b2.dwe = rdwe; b2.dre = rdre; b2.daddr = AW'(rda); b2.din = rdin;

            el = rq & ~m_iv;
            g = -1;
            for (int k = 0; k < 2; k++)
                if (g < 0 && el[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
            m_iv = '0;
            if (g >= 0) begin
                m_iv[g] = 1'b1;
                m_io[g] = imem_ref(ad[g]);
                m_ptr   = (g + 1) % 2;
            end
            m_dv = rdre;
            if (rdre) m_do = m_dm[rda];
            if (rdwe) m_dm[rda] = rdin;
        end
        tick();
        chk("rnd_end_ivalid", b2.ivalid, m_iv);
        chk("rnd_end_iout", b2.iout, m_io);
        chk("rnd_end_dout", b2.dout, m_do);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
